// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: funct3 codes, DMEM LenSel codes, FSM states and request decode helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Unsigned variants only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] f3_len(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return LEN_BYTE;
      2'b01:   return LEN_HALF;
      default: return LEN_WORD;
    endcase
  endfunction

  // Only meaningful for legal funct3; f3[1:0] then encodes the size.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extension: low-justified raw DMEM data + funct3 -> sign/zero-extended word.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_W:    rdata = raw;
      F3_BU:   rdata = {24'd0, raw[7:0]};
      F3_HU:   rdata = {16'd0, raw[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: request handshake -> single DMEM access -> registered response.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned H/W accesses as byte beats instead of erroring.
module lsu_ctrl
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DataW,
  input  logic [DATA_W-1:0] DataR,
  output logic              MemRW,
  output logic [LEN_W-1:0]  LenSel
);

  lsu_state_e        state_q, state_d;
  logic              rq_we_q, rq_we_d;
  logic [2:0]        rq_f3_q, rq_f3_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [LEN_W-1:0]  dmem_len_q, dmem_len_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ext;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        beat_nxt;
  logic [1:0]        beat_last;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [ADDR_W-1:0] rq_addr_q, rq_addr_d;
  logic [DATA_W-1:0] rq_wdata_q, rq_wdata_d;
`endif

  lsu_load_align u_align (
    .raw    (raw),
    .funct3 (rq_f3_q),
    .rdata  (ext)
  );

  always_comb begin
    state_d      = state_q;
    rq_we_d      = rq_we_q;
    rq_f3_d      = rq_f3_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_len_d   = dmem_len_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    raw          = DataR;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d    = split_q;
    beat_d     = beat_q;
    asm_d      = asm_q;
    rq_addr_d  = rq_addr_q;
    rq_wdata_d = rq_wdata_q;
    beat_nxt   = beat_q + 2'd1;
    beat_last  = (rq_f3_q == F3_W) ? 2'd3 : 2'd1;
    // Bytes land little-endian; the current beat's byte is merged combinationally.
    if (split_q)
      raw = asm_q | ({{(DATA_W-8){1'b0}}, DataR[7:0]} << {beat_q, 3'b000});
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rq_we_d     = req_we;
          rq_f3_d     = req_funct3;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (f3_illegal(req_funct3, req_we)) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d      = 1'b1;
            beat_d       = '0;
            asm_d        = '0;
            rq_addr_d    = req_addr;
            rq_wdata_d   = req_wdata;
            dmem_addr_d  = req_addr;
            dmem_wdata_d = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
            dmem_len_d   = LEN_BYTE;
            state_d      = ACC;
`else
            rsp_err_d = 1'b1;
            state_d   = RESP;
`endif
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d = 1'b0;
            beat_d  = '0;
`endif
            dmem_addr_d  = req_addr;
            dmem_wdata_d = req_wdata;
            dmem_len_d   = f3_len(req_funct3);
            state_d      = ACC;
          end
        end
      end
      ACC: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q && (beat_q != beat_last)) begin
          asm_d        = raw;
          beat_d       = beat_nxt;
          dmem_addr_d  = rq_addr_q + ADDR_W'(beat_nxt);
          dmem_wdata_d = {{(DATA_W-8){1'b0}}, rq_wdata_q[{beat_nxt, 3'b000} +: 8]};
        end else begin
          rsp_rdata_d = rq_we_q ? '0 : ext;
          state_d     = RESP;
        end
`else
        rsp_rdata_d = rq_we_q ? '0 : ext;
        state_d     = RESP;
`endif
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rq_we_q      <= 1'b0;
      rq_f3_q      <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_len_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      beat_q     <= '0;
      asm_q      <= '0;
      rq_addr_q  <= '0;
      rq_wdata_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rq_we_q      <= rq_we_d;
      rq_f3_q      <= rq_f3_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_len_q   <= dmem_len_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      rq_addr_q  <= rq_addr_d;
      rq_wdata_q <= rq_wdata_d;
`endif
    end
  end

  // Decoded from the state register so reset removes the write enable without a clock.
  assign MemRW     = (state_q == ACC) && rq_we_q;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign Addr      = dmem_addr_q;
  assign DataW     = dmem_wdata_q;
  assign LenSel    = dmem_len_q;

endmodule
